// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the decode-stage immediate generator.
//   imm_src_e : immediate format select (10-bit, 16-bit, 2-bit, none)
//   IMM*_W    : widths of the immediate fields within the instruction word.
//               Every field starts at bit 0 of the instruction word.
// ---------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_10   = 2'b00,
        IMM_16   = 2'b01,
        IMM_2    = 2'b10,
        IMM_NONE = 2'b11
    } imm_src_e;

    localparam int IMM10_W = 10;
    localparam int IMM16_W = 16;
    localparam int IMM2_W  = 2;

endpackage : imm_pkg

// File: rtl/imm_sext_comb.sv
// ---------------------------------------------------------------------------
// imm_sext_comb
// Pure combinational select-and-sign-extend of the immediate field.
// Ports:
//   field  in   IMM16_W  low bits of the instruction word. This is the widest
//                        field; the narrower fields are its low bits.
//   src    in   2        immediate format select (imm_src_e encoding)
//   imm    out  OUT_W    sign-extended immediate, 0 for IMM_NONE or an
//                        unknown select
// ---------------------------------------------------------------------------
module imm_sext_comb
    import imm_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic [IMM16_W-1:0] field,
    input  logic [1:0]         src,
    output logic [OUT_W-1:0]   imm
);

    always_comb begin
        // NOTE: assigning a default before the case means every path writes
        // imm, so no latch is inferred. It also makes an X/Z select decode to 0.
        imm = '0;
        case (src)
            IMM_10:   imm = {{(OUT_W-IMM10_W){field[IMM10_W-1]}}, field[IMM10_W-1:0]};
            IMM_16:   imm = {{(OUT_W-IMM16_W){field[IMM16_W-1]}}, field[IMM16_W-1:0]};
            IMM_2:    imm = {{(OUT_W-IMM2_W){field[IMM2_W-1]}},   field[IMM2_W-1:0]};
            IMM_NONE: imm = '0;
            default:  imm = '0;
        endcase
    end

endmodule : imm_sext_comb

// File: rtl/sign_extend_20.sv
// ---------------------------------------------------------------------------
// sign_extend_20
// Decode-stage immediate generator. It selects an immediate field from the
// instruction word, sign-extends the field to the datapath width, and
// registers the result. The latency is exactly one cycle and there is no
// enable: the register captures on every clock edge.
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous, active-high reset (clears Imm_Ext)
//   In       in   IN_W   instruction word
//   ImmSrc   in   2      immediate format select (imm_src_e encoding)
//   Imm_Ext  out  OUT_W  registered sign-extended immediate
// ---------------------------------------------------------------------------
module sign_extend_20
    import imm_pkg::*;
#(
    parameter int IN_W  = 34,
    parameter int OUT_W = 24   // must be >= IMM16_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   In,
    input  logic [1:0]        ImmSrc,
    output logic [OUT_W-1:0]  Imm_Ext
);

    logic [OUT_W-1:0] imm_next;

    // Instruction bits above the widest field never reach the immediate.
    logic unused_hi;
    assign unused_hi = ^In[IN_W-1:IMM16_W];

    imm_sext_comb #(
        .OUT_W (OUT_W)
    ) u_sext (
        .field (In[IMM16_W-1:0]),
        .src   (ImmSrc),
        .imm   (imm_next)
    );

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) Imm_Ext <= '0;
        else     Imm_Ext <= imm_next;
    end

    // Design-intent checks
    a_out_width: assert property (@(posedge clk) $bits(Imm_Ext) == OUT_W);

    a_reset_zero: assert property (@(posedge clk) rst |-> (Imm_Ext == '0));

    a_one_cycle: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (Imm_Ext == $past(imm_next)));

endmodule : sign_extend_20

// File: tb/tb_sign_extend_20.sv
// ---------------------------------------------------------------------------
// tb_sign_extend_20
// Directed testbench for sign_extend_20. The bench drives inputs just after a
// falling edge and samples outputs at the next falling edge, which is half a
// cycle after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_sign_extend_20;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] in_w;
    logic [1:0]  imm_src;
    logic [23:0] imm_ext;

    int total = 0;
    int bad   = 0;

    sign_extend_20 #(
        .IN_W  (34),
        .OUT_W (24)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .In      (in_w),
        .ImmSrc  (imm_src),
        .Imm_Ext (imm_ext)
    );

    always #5 clk = ~clk;

    // Drives one vector, lets one rising edge capture it, and returns at the
    // following falling edge.
    task automatic apply(input logic [1:0] src, input logic [33:0] word);
        imm_src = src;
        in_w    = word;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        imm_src = 2'b01;
        in_w    = 34'h0_0000_3333;
        repeat (2) @(negedge clk);
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", imm_ext, 24'h000000);
        end
        rst = 1'b0;
    endtask

    task automatic test_imm10();
        apply(2'b00, 34'h0_0000_000C);
        total++;
        if (imm_ext !== 24'h00000C) begin
            bad++;
            $display("FAIL imm10_pos: got %h want %h", imm_ext, 24'h00000C);
        end
        apply(2'b00, 34'h0_0000_0200);
        total++;
        if (imm_ext !== 24'hFFFE00) begin
            bad++;
            $display("FAIL imm10_neg: got %h want %h", imm_ext, 24'hFFFE00);
        end
        apply(2'b00, 34'h0_0000_01FF);
        total++;
        if (imm_ext !== 24'h0001FF) begin
            bad++;
            $display("FAIL imm10_maxpos: got %h want %h", imm_ext, 24'h0001FF);
        end
    endtask

    task automatic test_imm16();
        apply(2'b01, 34'h0_0000_3333);
        total++;
        if (imm_ext !== 24'h003333) begin
            bad++;
            $display("FAIL imm16_pos: got %h want %h", imm_ext, 24'h003333);
        end
        apply(2'b01, 34'h0_0000_CCCC);
        total++;
        if (imm_ext !== 24'hFFCCCC) begin
            bad++;
            $display("FAIL imm16_neg: got %h want %h", imm_ext, 24'hFFCCCC);
        end
    endtask

    task automatic test_imm2();
        apply(2'b10, 34'h0_0000_0003);
        total++;
        if (imm_ext !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL imm2_neg: got %h want %h", imm_ext, 24'hFFFFFF);
        end
        apply(2'b10, 34'h0_0000_0001);
        total++;
        if (imm_ext !== 24'h000001) begin
            bad++;
            $display("FAIL imm2_pos: got %h want %h", imm_ext, 24'h000001);
        end
        apply(2'b10, 34'h0_0000_0002);
        total++;
        if (imm_ext !== 24'hFFFFFE) begin
            bad++;
            $display("FAIL imm2_min: got %h want %h", imm_ext, 24'hFFFFFE);
        end
    endtask

    task automatic test_none();
        apply(2'b11, 34'h0_0000_000C);
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL none_c: got %h want %h", imm_ext, 24'h000000);
        end
        apply(2'b11, 34'h3_FFFF_FFFF);
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL none_ones: got %h want %h", imm_ext, 24'h000000);
        end
    endtask

    task automatic test_isolation();
        apply(2'b00, 34'h3_FFFF_FC00);
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL iso_imm10: got %h want %h", imm_ext, 24'h000000);
        end
        apply(2'b01, 34'h3_FFFF_0123);
        total++;
        if (imm_ext !== 24'h000123) begin
            bad++;
            $display("FAIL iso_imm16: got %h want %h", imm_ext, 24'h000123);
        end
        apply(2'b10, 34'h3_FFFF_FFFD);
        total++;
        if (imm_ext !== 24'h000001) begin
            bad++;
            $display("FAIL iso_imm2: got %h want %h", imm_ext, 24'h000001);
        end
    endtask

    // The output must hold between edges when inputs change.
    task automatic test_hold();
        apply(2'b01, 34'h0_0000_3333);
        #1;
        in_w    = 34'h0_0000_CCCC;
        imm_src = 2'b01;
        #2;
        total++;
        if (imm_ext !== 24'h003333) begin
            bad++;
            $display("FAIL hold_between_edges: got %h want %h", imm_ext, 24'h003333);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (imm_ext !== 24'hFFCCCC) begin
            bad++;
            $display("FAIL hold_next_edge: got %h want %h", imm_ext, 24'hFFCCCC);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  srcs [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [33:0] words[5] = '{34'h0_0000_000C, 34'h0_0000_8000,
                                  34'h0_0000_0002, 34'h0_0000_0200,
                                  34'h0_0000_03FF};
        logic [23:0] exps [5] = '{24'h00000C, 24'hFF8000, 24'hFFFFFE,
                                  24'h000000, 24'hFFFFFF};
        for (int i = 0; i < 5; i++) begin
            apply(srcs[i], words[i]);
            total++;
            if (imm_ext !== exps[i]) begin
                bad++;
                $display("FAIL b2b_%0d: got %h want %h", i, imm_ext, exps[i]);
            end
        end
    endtask

    // Reset is asserted mid-cycle and must clear the output without a clock edge.
    task automatic test_async_reset();
        apply(2'b00, 34'h0_0000_0200);
        total++;
        if (imm_ext !== 24'hFFFE00) begin
            bad++;
            $display("FAIL arst_pre: got %h want %h", imm_ext, 24'hFFFE00);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL arst_immediate: got %h want %h", imm_ext, 24'h000000);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (imm_ext !== 24'h000000) begin
            bad++;
            $display("FAIL arst_held: got %h want %h", imm_ext, 24'h000000);
        end
        rst = 1'b0;
        apply(2'b01, 34'h0_0000_3333);
        total++;
        if (imm_ext !== 24'h003333) begin
            bad++;
            $display("FAIL arst_resume: got %h want %h", imm_ext, 24'h003333);
        end
    endtask

    initial begin
        rst     = 1'b1;
        imm_src = 2'b00;
        in_w    = '0;
        test_reset();
        test_imm10();
        test_imm16();
        test_imm2();
        test_none();
        test_isolation();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sign_extend_20
